// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter: one operand bit per clock, add-3 correction
// on every digit before each shift, result and done pulse registered on the last step.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int ACCW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 1 || WIDTH > 32 || pow10(DIGITS) <= MAX_BIN) begin : g_bad_params
      $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d (or WIDTH out of 1..32)",
             DIGITS, WIDTH);
    end
  endgenerate

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0]   bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ACCW-1:0]   accCorr;
  logic [ACCW-1:0]   accShifted;

  // Digits 10..15 never occur in legal operation; forcing them to 0 keeps the logic total.
  function automatic logic [ACCW-1:0] corr(input logic [ACCW-1:0] a);
    logic [ACCW-1:0] r;
    logic [3:0]      dig;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = a[4*k +: 4];
      if (dig <= 4'd4)      r[4*k +: 4] = dig;
      else if (dig <= 4'd9) r[4*k +: 4] = dig + 4'd3;
      else                  r[4*k +: 4] = 4'd0;
    end
    return r;
  endfunction

  assign accCorr    = corr(acc_q);
  assign accShifted = {accCorr[ACCW-2:0], sr_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = bus.bin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = accShifted;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST_STEP) begin
          bcd_d   = accShifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scenario tasks plus a scoreboard queue of expected
// BCD results fed by a decimal-digit model.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk;
  logic rst;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;
  int doneCount;
  logic [4*DIGITS-1:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) doneCount++;

  function automatic logic [11:0] model(input int v);
    logic [11:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives a one-cycle start and queues the expected result; returns just after the accepting edge.
  task automatic applyStimulus(input int v, input bit expectResult);
    bus.bin   = WIDTH'(v);
    bus.start = 1'b1;
    if (expectResult) expQ.push_back(model(v));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitForDone(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 50 && !ok) begin
      tick();
      cycles++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", i, bus.busy);
      end
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_done cycle %0d: got %b expected 0", i, bus.done);
      end
      total++;
      if (bus.bcd !== 12'h000) begin
        bad++;
        $display("[TB] FAIL reset_bcd cycle %0d: got %h expected 000", i, bus.bcd);
      end
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_max_value();
    logic [11:0] exp;
    applyStimulus(255, 1'b1);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL max_busy_accept: got %b expected 1", bus.busy);
    end
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL max_busy_step%0d: got busy=%b done=%b expected busy=1 done=0",
                 i, bus.busy, bus.done);
      end
    end
    tick();
    exp = expQ.pop_front();
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL max_done_pulse: got done=%b busy=%b expected done=1 busy=0",
               bus.done, bus.busy);
    end
    total++;
    if (bus.bcd !== exp) begin
      bad++;
      $display("[TB] FAIL max_bcd: got %h expected %h", bus.bcd, exp);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.bcd !== exp) begin
      bad++;
      $display("[TB] FAIL max_after_done: got done=%b bcd=%h expected done=0 bcd=%h",
               bus.done, bus.bcd, exp);
    end
  endtask

  task automatic test_boundaries();
    int vals[5] = '{0, 9, 99, 100, 128};
    int cycles;
    bit ok;
    logic [11:0] exp;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vals[i], 1'b1);
      waitForDone(cycles, ok);
      exp = expQ.pop_front();
      total++;
      if (!ok || cycles != WIDTH) begin
        bad++;
        $display("[TB] FAIL bound_latency bin=%0d: got %0d cycles (done=%b) expected %0d",
                 vals[i], cycles, ok, WIDTH);
      end
      total++;
      if (bus.bcd !== exp) begin
        bad++;
        $display("[TB] FAIL bound_bcd bin=%0d: got %h expected %h", vals[i], bus.bcd, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit ok;
    logic [11:0] exp;
    bus.bin   = 8'd42;
    bus.start = 1'b1;
    expQ.push_back(model(42));
    tick();
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 50 && !ok) begin
      bus.bin = WIDTH'($urandom_range(0, 255));
      tick();
      cycles++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
    exp = expQ.pop_front();
    total++;
    if (!ok || cycles != WIDTH) begin
      bad++;
      $display("[TB] FAIL b2b_first_latency: got %0d cycles (done=%b) expected %0d",
               cycles, ok, WIDTH);
    end
    total++;
    if (bus.bcd !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_first_bcd: got %h expected %h", bus.bcd, exp);
    end
    bus.bin = 8'd137;
    expQ.push_back(model(137));
    tick();
    bus.start = 1'b0;
    cycles = 1;
    ok     = 1'b0;
    while (cycles < 50 && !ok) begin
      bus.bin = WIDTH'($urandom_range(0, 255));
      tick();
      cycles++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
    exp = expQ.pop_front();
    total++;
    if (!ok || cycles != WIDTH + 1) begin
      bad++;
      $display("[TB] FAIL b2b_done_spacing: got %0d cycles (done=%b) expected %0d",
               cycles, ok, WIDTH + 1);
    end
    total++;
    if (bus.bcd !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_second_bcd: got %h expected %h", bus.bcd, exp);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int cycles;
    bit ok;
    int doneSeen;
    logic [11:0] exp;
    applyStimulus(200, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 12'h000) begin
      bad++;
      $display("[TB] FAIL abort_state: got busy=%b done=%b bcd=%h expected busy=0 done=0 bcd=000",
               bus.busy, bus.done, bus.bcd);
    end
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) doneSeen++;
    end
    total++;
    if (doneSeen != 0 || bus.bcd !== 12'h000) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got %0d pulses bcd=%h expected 0 pulses bcd=000",
               doneSeen, bus.bcd);
    end
    applyStimulus(7, 1'b1);
    waitForDone(cycles, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || cycles != WIDTH) begin
      bad++;
      $display("[TB] FAIL abort_next_latency: got %0d cycles (done=%b) expected %0d",
               cycles, ok, WIDTH);
    end
    total++;
    if (bus.bcd !== exp) begin
      bad++;
      $display("[TB] FAIL abort_next_bcd: got %h expected %h", bus.bcd, exp);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int cycles;
    bit ok;
    int doneBase;
    logic [11:0] exp;
    tick();
    doneBase = doneCount;
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(v, 1'b1);
      waitForDone(cycles, ok);
      exp = expQ.pop_front();
      total++;
      if (!ok || bus.bcd !== exp) begin
        bad++;
        $display("[TB] FAIL exh_bcd bin=%0d: got %h (done=%b) expected %h", v, bus.bcd, ok, exp);
      end
    end
    tick();
    tick();
    total++;
    if (doneCount - doneBase != 256 || expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL exh_done_count: got %0d pulses queue=%0d expected 256 pulses queue=0",
               doneCount - doneBase, expQ.size());
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    doneCount = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.bin   = 8'd255;
    $display("[TB] starting bin2bcd_seq checks");
    test_reset();
    test_max_value();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
